// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receive path, transmit path and
// baud-tick generator.
//   UART_DATA_BITS  : default payload width (LSB first on the wire)
//   UART_OVERSAMPLE : default tick_16x pulses per bit period
//   ST_*            : 2-bit FSM state encoding used by the receiver
//   cnt_width()     : counter width helper that never returns zero
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef logic [1:0] uart_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Bits needed to count 0..n-1; at least one bit so degenerate sizes still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for a single asynchronous input.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset; both flops load RESET_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clk_i cycles behind d_i
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver using an OVERSAMPLE x baud enable tick.
//   clk_50M   : system clock
//   rst_n     : asynchronous active-low reset
//   tick_16x  : one-cycle enable at OVERSAMPLE x baud
//   RX_D      : serial line (asynchronous, idles high)
//   rx_ack    : consumer took rx_data (single-cycle pulse)
//   rx_data   : last good byte (holding register)
//   rx_valid  : rx_data holds an unacknowledged byte
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : sticky, a byte was overwritten before rx_ack
//   busy      : receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 RX_D,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(OVERSAMPLE);
  localparam int IDX_W = cnt_width(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 over_q, over_d;
  logic                 load;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clk_50M),
    .rst_ni (rst_n),
    .d_i    (RX_D),
    .q_o    (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    over_d  = over_q;
    ferr_d  = 1'b0;
    load    = 1'b0;

    if (tick_16x) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d = ST_DATA;
              idx_d   = '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_END) begin
            // Right shift into the MSB so the first (LSB) bit ends up at bit 0.
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_END) begin
            // Leave at mid stop bit so the next start edge has half a bit of margin.
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (rx_s) begin
              load = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      over_d  = 1'b0;
    end

    // A load takes priority over a coincident ack; the ack only suppresses overrun.
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ack) begin
        over_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      over_q  <= over_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = over_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
